// File: rtl/addressed_interconnect_hub_if.sv
// Handshake bundle between the hub, the SPI minion adapter and the on-chip modules.
// The slave modport is the hub side and the master modport is the environment side.
interface addressed_interconnect_hub_if #(
  parameter int BIT_WIDTH  = 32,
  parameter int N_PORTS    = 16,
  parameter int ADDR_WIDTH = $clog2(N_PORTS)
);
  logic                            recv_val;
  logic                            recv_rdy;
  logic [ADDR_WIDTH+BIT_WIDTH-1:0] recv_msg;

  logic                            send_val;
  logic                            send_rdy;
  logic [ADDR_WIDTH+BIT_WIDTH-1:0] send_msg;

  logic [N_PORTS-1:0]              src_val;
  logic [N_PORTS-1:0]              src_rdy;
  logic [BIT_WIDTH-1:0]            src_msg [N_PORTS];

  logic [N_PORTS-1:0]              snk_val;
  logic [N_PORTS-1:0]              snk_rdy;
  logic [BIT_WIDTH-1:0]            snk_msg [N_PORTS];

  modport slave (
    input  recv_val, recv_msg, send_rdy, src_rdy, snk_val, snk_msg,
    output recv_rdy, send_val, send_msg, src_val, src_msg, snk_rdy
  );

  modport master (
    output recv_val, recv_msg, send_rdy, src_rdy, snk_val, snk_msg,
    input  recv_rdy, send_val, send_msg, src_val, src_msg, snk_rdy
  );
endinterface

// File: rtl/addressed_interconnect_hub.sv
// Address router with per-port outbound FIFOs, round-robin return-path arbiter,
// optional port-0 loopback and a saturating drop counter for unroutable packets.
module addressed_interconnect_hub #(
  parameter int BIT_WIDTH   = 32,
  parameter int N_PORTS     = 16,
  parameter int ADDR_WIDTH  = $clog2(N_PORTS),
  parameter int FIFO_DEPTH  = 2,
  parameter int LOOPBACK_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  addressed_interconnect_hub_if.slave bus,
  input  logic [N_PORTS-1:0]   port_en,
  output logic [7:0]           drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [N_PORTS-1:0] LB_MASK = (LOOPBACK_EN != 0) ? N_PORTS'(1) : '0;

  logic [BIT_WIDTH-1:0]  mem [N_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr [N_PORTS];
  logic [PTR_W-1:0]      wr_ptr [N_PORTS];
  logic [CNT_W-1:0]      count  [N_PORTS];
  logic [N_PORTS-1:0]    nonempty;
  logic [N_PORTS-1:0]    push;
  logic [N_PORTS-1:0]    pop;

  logic [ADDR_WIDTH-1:0] recv_addr;
  logic [BIT_WIDTH-1:0]  recv_data;
  logic                  addr_ok;
  logic                  sel_full;
  logic                  recv_rdy_int;
  logic                  drop;

  logic [N_PORTS-1:0]    req;
  logic [BIT_WIDTH-1:0]  arb_data [N_PORTS];
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] gnt_idx;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic                  gnt_found;
  logic                  grant_valid;
  logic [N_PORTS-1:0]    grant;
  logic [BIT_WIDTH-1:0]  gnt_data;

  logic                            out_full;
  logic [ADDR_WIDTH+BIT_WIDTH-1:0] out_msg;

  assign recv_addr = bus.recv_msg[BIT_WIDTH+ADDR_WIDTH-1:BIT_WIDTH];
  assign recv_data = bus.recv_msg[BIT_WIDTH-1:0];

  // Out-of-range addresses never match a port, so they fall through as invalid.
  always_comb begin
    addr_ok  = 1'b0;
    sel_full = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (recv_addr == ADDR_WIDTH'(i)) begin
        addr_ok  = port_en[i];
        sel_full = (count[i] == CNT_W'(FIFO_DEPTH));
      end
    end
  end

  assign recv_rdy_int = !reset && (!addr_ok || !sel_full);
  assign drop         = bus.recv_val && recv_rdy_int && !addr_ok;

  always_comb begin
    push = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      push[i] = bus.recv_val && recv_rdy_int && addr_ok && (recv_addr == ADDR_WIDTH'(i));
    end
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    assign nonempty[i]    = (count[i] != '0);
    assign bus.src_msg[i] = mem[i][rd_ptr[i]];
  end

  assign pop = (nonempty & bus.src_rdy & ~LB_MASK) | (grant & LB_MASK);

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= recv_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // With loopback, input 0 of the arbiter is the port-0 FIFO head, not snk[0].
  always_comb begin
    req = bus.snk_val;
    for (int i = 0; i < N_PORTS; i++) arb_data[i] = bus.snk_msg[i];
    if (LOOPBACK_EN != 0) begin
      req[0]      = nonempty[0];
      arb_data[0] = mem[0][rd_ptr[0]];
    end
  end

  always_comb begin : arb
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ADDR_WIDTH'(idx);
      end
    end
  end

  assign grant_valid = !reset && gnt_found && (!out_full || bus.send_rdy);
  assign gnt_data    = arb_data[gnt_idx];
  assign ptr_next    = (gnt_idx == ADDR_WIDTH'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    grant = '0;
    if (grant_valid) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_full   <= 1'b0;
      out_msg    <= '0;
      ptr        <= '0;
      drop_count <= '0;
    end else begin
      if (grant_valid) begin
        out_full <= 1'b1;
        out_msg  <= {gnt_idx, gnt_data};
        ptr      <= ptr_next;
      end else if (bus.send_rdy) begin
        out_full <= 1'b0;
      end
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  assign bus.recv_rdy = recv_rdy_int;
  assign bus.send_val = out_full && !reset;
  assign bus.send_msg = out_msg;
  assign bus.src_val  = nonempty & ~LB_MASK & {N_PORTS{!reset}};
  assign bus.snk_rdy  = grant & ~LB_MASK;

endmodule

// File: doc/addressed_interconnect_hub.md
# addressed_interconnect_hub

Parametrised successor to the fixed 16-address packet interconnect. It merges the address router and the return-path arbiter into one block, and adds three things: per-port output buffering, round-robin fairness, and drop accounting for disabled or out-of-range addresses. It sits between the control SPI minion adapter and the on-chip modules (crossbars, SPI master configuration, FFT path). Address 0 can optionally be an internal loopback.

## Interface
Parameters:
- `BIT_WIDTH`, 32, payload width.
- `N_PORTS`, 16, number of addressable ports, from 2 to 64. Need not be a power of two.
- `ADDR_WIDTH`, `$clog2(N_PORTS)`, width of the address field.
- `FIFO_DEPTH`, 2, entries per outbound port FIFO. Power of two, at least 2.
- `LOOPBACK_EN`, 1, when 1, port 0 is an internal loopback.

Ports:
- `clk`, in, 1, the single clock.
- `reset`, in, 1, synchronous, active-high.
- `recv_val`, `recv_rdy` (out), `recv_msg`, in, 1/1/`BIT_WIDTH+ADDR_WIDTH`, packets from the adapter. `{addr, data}` with the address in the MSBs.
- `send_val` (out), `send_rdy` (in), `send_msg` (out), 1/1/`BIT_WIDTH+ADDR_WIDTH`, packets to the adapter. `{source port, data}`.
- `src_val` out, `src_rdy` in, `src_msg` out, `[0:N_PORTS-1]` arrays, 1/1/`BIT_WIDTH` each, outbound data to the modules.
- `snk_val` in, `snk_rdy` out, `snk_msg` in, `[0:N_PORTS-1]` arrays, 1/1/`BIT_WIDTH` each, inbound data from the modules.
- `port_en`, in, `N_PORTS`, per-port enable. Static during traffic.
- `drop_count`, out, 8, saturating count of dropped packets.

## Operation
- **Decode:** `addr = recv_msg[BIT_WIDTH+ADDR_WIDTH-1:BIT_WIDTH]`, `data = recv_msg[BIT_WIDTH-1:0]`.
- **Routing:** packets with a valid address are pushed into that port's FIFO.
  - The address is valid when `addr < N_PORTS` and `port_en[addr]` is 1.
  - `recv_rdy` is 1 when the addressed FIFO is not full.
- **Drops:** a packet with an invalid address is still accepted (`recv_rdy` = 1), then discarded, and `drop_count` increments.
  - `drop_count` saturates at 255.
- **Outbound drain:** each FIFO drains independently.
  - `src_val[i]` is 1 when FIFO i is not empty.
  - `src_msg[i]` is the FIFO head.
  - The head pops when `src_val[i]` and `src_rdy[i]` are both 1.
- **Loopback (`LOOPBACK_EN`=1):**
  - The port 0 FIFO head feeds arbiter input 0 in place of `snk[0]`.
  - Internal ready for that input is the arbiter grant to input 0.
  - External `src_val[0]` = 0 and `snk_rdy[0]` = 0.
- **Arbiter:** round-robin over the inbound requests (`snk_val[i]` for i ≥ 1, plus input 0 as described above).
  - The priority pointer `ptr` resets to 0.
  - Each cycle, the first requester at or after `ptr`, wrapping around, is granted, but only if the output register can accept.
  - After a grant to input g, `ptr` becomes (g+1) mod `N_PORTS`. With no grant, `ptr` is unchanged.
  - `snk_rdy[i]` = grant[i].
- **Output register:** one entry holding `{g, data}`.
  - It can accept a new entry when it is empty, or when it is full and `send_rdy` is 1 in the same cycle. This gives full throughput.
- **Static enable:** `port_en` gates only the downstream routing. Inbound traffic from disabled ports is still arbitrated.

## Timing
- **Reset values:**
  - `recv_rdy`, `send_val` and every `src_val` and `snk_rdy` are 0 while `reset` is high.
  - All FIFOs are empty, `drop_count` = 0, `ptr` = 0, `send_msg` = 0.
- **Downstream latency:** a packet accepted in cycle t appears on `src_val` in cycle t+1. There is no bypass.
- **Upstream latency:** a grant in cycle t gives `send_val` in cycle t+1.
- **Loopback latency:** 2 cycles from `recv` acceptance to `send_val`, when uncontended.
- **Ready timing:** `recv_rdy` depends only on the registered FIFO count and `port_en`, never on `src_rdy`.
  - A full FIFO deasserts `recv_rdy` even when it pops in the same cycle.
  - A packet blocked behind a full FIFO blocks every following packet (head-of-line blocking).
- **FIFO push and pop in the same cycle:** allowed when the FIFO is neither empty nor full; the count is unchanged. The read and write pointers wrap modulo `FIFO_DEPTH`.
- **Backpressure:** `send_val`/`send_msg` hold stable while `send_rdy` = 0. No grants are issued while the register is full and not draining.
- **Counter:** `drop_count` updates in the cycle after the drop. At 255 it holds.
- **Reset mid-operation:** all buffered packets are discarded and nothing is emitted. Transfers resume on the first cycle after `reset` falls.

## Test plan
- **Single packet:** after reset, send `{addr=3, 0xDEADBEEF}` with `src_rdy[3]` = 1. `src_val[3]` rises exactly 1 cycle later with `src_msg[3]` = 0xDEADBEEF; no other `src_val` toggles.
- **Loopback:** send `{0, 0x12345678}` with `send_rdy` = 1. `send_msg` = `{0, 0x12345678}` with `send_val` 2 cycles after acceptance.
- **Fill and backpressure:** with `FIFO_DEPTH`=2, push 3 packets to address 5 while `src_rdy[5]` = 0.
  - `recv_rdy` = 0 on the 3rd packet.
  - Raise `src_rdy[5]`: the packets drain in order and the 3rd packet is accepted on the cycle after the first pop.
- **Round-robin:** hold `snk_val[2]`, `snk_val[7]` and `snk_val[9]` high with `send_rdy` = 1. The grant order is 2, 7, 9, 2, 7, 9, with one `send_val` per cycle and source fields matching.
- **Drops:** with `port_en[4]` = 0 and `N_PORTS`=12:
  - Send to addresses 4 and 13: both are accepted, nothing is emitted, and `drop_count` = 2.
  - Send 300 drops in total: `drop_count` = 255.
- **Stall and reset:** with `send_rdy` = 0 and `snk_val[1]` = 1, `send_msg` holds and `snk_rdy[1]` = 0 after the first grant. Asserting `reset` mid-stream clears every `val` output the next cycle and returns `drop_count` to 0.
